fsm_trend_monitor: RTL
======================

Name: fsm_trend_monitor

Overview:
Parametrised level-trend state machine, successor of the 5-state casex FSM.
- Classifies a multi-bit sampled level into JOS/MIJLOC/SUS zones using programmable thresholds, instead of three one-hot inputs.
- Adds debounce, separate up/down event counters, an inactivity timeout and a state-change strobe.
- Sits between an ADC/sensor sampler and the control/status logic; stare is directly observable.

Parameters:
LVL_W, 8, width of sampled level and thresholds
CNT_W, 8, width of up/down event counters (saturating)
DEB, 2, consecutive same-zone valid samples required to leave REGULAR/SINGLE_* (legal 1..15)
TMO, 16, cycles without smp_valid before forced return to IDLE (legal 2..2^16-1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  begin a monitoring session (honoured only in IDLE)
sfarsit  in  1  end session
smp_valid  in  1  smp_level is valid this cycle
smp_level  in  LVL_W  sampled level, unsigned
thr_lo  in  LVL_W  low threshold, unsigned, quasi-static
thr_hi  in  LVL_W  high threshold, unsigned, quasi-static
stare  out  3  current state code (registered)
stare_chg  out  1  high for exactly one cycle, the first cycle stare shows a new value
up_cnt  out  CNT_W  number of entries into SINGLE_UP this session
down_cnt  out  CNT_W  number of entries into SINGLE_DOWN this session
timeout  out  1  session ended by inactivity; sticky until next accepted start

Behaviour:
- Reset (async, rst_n=0):
  - stare=000 (IDLE); stare_chg=0; up_cnt=0; down_cnt=0; timeout=0.
  - Debounce run counter, pending zone and timeout counter are cleared.
- State codes: IDLE 000, INITIAL 001, REGULAR 010, SINGLE_UP 011, SINGLE_DOWN 100.
  - Codes 101..111 are illegal; they go to IDLE on the next edge with stare_chg=1.
- Zone classification (unsigned compare, thresholds inclusive):
  - JOS if level < thr_lo.
  - SUS if level > thr_hi.
  - MIJLOC otherwise.
  - If thr_lo > thr_hi, every sample is MIJLOC.
  - Zone-to-state mapping: MIJLOC->REGULAR, SUS->SINGLE_UP, JOS->SINGLE_DOWN.
- IDLE:
  - start=1 -> INITIAL.
  - On the same edge, clear up_cnt, down_cnt, timeout, the run counter and the timeout counter.
  - sfarsit and samples are ignored in IDLE.
- INITIAL:
  - Priority order: sfarsit=1 -> IDLE; otherwise timeout; otherwise a valid sample.
  - The first valid sample moves directly to its mapped state. No debounce applies.
  - Entering SINGLE_UP/SINGLE_DOWN from INITIAL counts as an entry.
- REGULAR / SINGLE_UP / SINGLE_DOWN:
  - Priority order: sfarsit > timeout > sample.
  - sfarsit=1 -> IDLE regardless of smp_valid. Counters hold their values.
  - A valid sample mapping to the current state clears the run counter.
  - A valid sample mapping to another state:
    - If its zone equals the pending zone, increment the run counter.
    - Otherwise set pending zone = that zone and run = 1.
    - When run reaches DEB, transition on that same edge and clear run.
    - With DEB=1 the transition happens on the first differing sample.
  - Cycles with smp_valid=0 leave the run counter unchanged. Debounce counts samples, not cycles.
- Timeout:
  - In any non-IDLE state the counter increments each cycle with smp_valid=0 and clears when smp_valid=1.
  - When it reaches TMO: go to IDLE, set timeout=1 and clear the counter.
  - sfarsit on the same edge wins; timeout stays 0 in that case.
- Counters:
  - up_cnt increments on every edge whose next state is SINGLE_UP and whose current state is not SINGLE_UP. down_cnt behaves the same for SINGLE_DOWN.
  - Both saturate at 2^CNT_W-1.
  - Both are readable and held in IDLE until the next accepted start.
- Latency: one clock from the deciding input (start, sfarsit, or the DEB-th sample) to the new stare value.
- start while not in IDLE is ignored. Multiple changes cannot occur in one cycle.

Decomposition:
- Package fsm_trend_pkg holds:
  - state localparams (S_IDLE..S_SINGLE_DOWN);
  - zone codes (Z_JOS=2'b00, Z_MIJLOC=2'b01, Z_SUS=2'b10);
  - the zone-to-state mapping function.
- One combinational sub-module, trend_zone_cmp (smp_level, thr_lo, thr_hi -> 2-bit zone), contains the invalid-threshold rule.
- The FSM, debounce, timeout and counters stay in the top module.

Test Plan:
All scenarios use LVL_W=8, thr_lo=64, thr_hi=192, DEB=2, TMO=16, CNT_W=8 unless noted.
1. Reset, start pulse -> stare=001 next cycle, stare_chg=1 for one cycle; valid level=100 -> stare=010; valid level=30 from INITIAL -> stare=100, down_cnt=1.
2. In REGULAR, valid levels 200,100,200,200 -> stare stays 010 through the third sample; 011 after the fourth; up_cnt=1; exactly one stare_chg pulse. Repeat with DEB=1: 010->011 on the first 200.
3. Boundaries: levels 64 and 192 -> MIJLOC (stare stays 010); 63,63 -> 100; 193,193 -> 011. Set thr_lo=200, thr_hi=50, levels 0 and 255 -> stare stays 010.
4. In SINGLE_UP, assert sfarsit together with valid level=10 -> IDLE next cycle, timeout=0, up_cnt held. Then start -> counters cleared to 0.
5. In REGULAR, hold smp_valid=0 for 15 cycles -> still 010; 16th cycle -> 000 with timeout=1. Sfarsit in the 16th cycle -> IDLE with timeout=0. Next start clears timeout.
6. CNT_W=2: alternate 200,200,100,100 five times -> up_cnt saturates at 3. Assert rst_n=0 asynchronously mid-debounce -> all outputs reset immediately; after release, valid samples are ignored until start.

Source files
------------

// File: rtl/fsm_trend_pkg.sv
// Shared state codes, zone codes and the zone-to-state mapping for the trend monitor.
package fsm_trend_pkg;

   typedef enum logic [2:0] {
      S_IDLE        = 3'b000,
      S_INITIAL     = 3'b001,
      S_REGULAR     = 3'b010,
      S_SINGLE_UP   = 3'b011,
      S_SINGLE_DOWN = 3'b100
   } state_e;

   localparam logic [1:0] Z_JOS    = 2'b00;
   localparam logic [1:0] Z_MIJLOC = 2'b01;
   localparam logic [1:0] Z_SUS    = 2'b10;

   function automatic logic [2:0] zone2state(input logic [1:0] zone);
      case (zone)
         Z_SUS:   zone2state = S_SINGLE_UP;
         Z_JOS:   zone2state = S_SINGLE_DOWN;
         default: zone2state = S_REGULAR;
      endcase
   endfunction

endpackage

// File: rtl/fsm_trend_monitor_zone_cmp.sv
// Classifies a sampled level against inclusive low/high thresholds.
module trend_zone_cmp
   import fsm_trend_pkg::*;
#(
   parameter int LVL_W = 8
) (
   input  logic [LVL_W-1:0] smp_level,
   input  logic [LVL_W-1:0] thr_lo,
   input  logic [LVL_W-1:0] thr_hi,
   output logic [1:0]       zone
);

   always_comb begin
      zone = Z_MIJLOC;
      // Crossed thresholds describe an empty band, so nothing can leave the middle zone.
      if (thr_lo > thr_hi)          zone = Z_MIJLOC;
      else if (smp_level < thr_lo)  zone = Z_JOS;
      else if (smp_level > thr_hi)  zone = Z_SUS;
   end

endmodule

// File: rtl/fsm_trend_monitor.sv
// Level-trend FSM with debounced zone changes, up/down entry counters and inactivity timeout.
module fsm_trend_monitor
   import fsm_trend_pkg::*;
#(
   parameter int LVL_W = 8,
   parameter int CNT_W = 8,
   parameter int DEB   = 2,
   parameter int TMO   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sfarsit,
   input  logic             smp_valid,
   input  logic [LVL_W-1:0] smp_level,
   input  logic [LVL_W-1:0] thr_lo,
   input  logic [LVL_W-1:0] thr_hi,
   output logic [2:0]       stare,
   output logic             stare_chg,
   output logic [CNT_W-1:0] up_cnt,
   output logic [CNT_W-1:0] down_cnt,
   output logic             timeout
);

   localparam int             TW      = $clog2(TMO + 1);
   localparam logic [3:0]     DEB_V   = 4'(DEB);
   localparam logic [TW-1:0]  TMO_V   = TW'(TMO);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]    zone, pend, pend_n;
   logic [2:0]    smp_st, nxt;
   logic [3:0]    run, run_n, run_inc;
   logic [TW-1:0] tmo_cnt, tmo_n, tmo_inc;
   logic          timeout_n, clr_cnt;

   trend_zone_cmp #(.LVL_W(LVL_W)) u_zone_cmp (
      .smp_level (smp_level),
      .thr_lo    (thr_lo),
      .thr_hi    (thr_hi),
      .zone      (zone)
   );

   assign smp_st  = zone2state(zone);
   assign run_inc = (zone == pend) ? run + 4'd1 : 4'd1;
   assign tmo_inc = tmo_cnt + TW'(1);

   always_comb begin
      nxt       = stare;
      run_n     = run;
      pend_n    = pend;
      tmo_n     = tmo_cnt;
      timeout_n = timeout;
      clr_cnt   = 1'b0;
      case (stare)
         S_IDLE: begin
            if (start) begin
               nxt       = S_INITIAL;
               clr_cnt   = 1'b1;
               timeout_n = 1'b0;
               run_n     = '0;
               tmo_n     = '0;
            end
         end
         S_INITIAL, S_REGULAR, S_SINGLE_UP, S_SINGLE_DOWN: begin
            tmo_n = smp_valid ? '0 : tmo_inc;
            if (sfarsit) begin
               nxt   = S_IDLE;
               run_n = '0;
               tmo_n = '0;
            end else if (!smp_valid) begin
               if (tmo_inc == TMO_V) begin
                  nxt       = S_IDLE;
                  timeout_n = 1'b1;
                  run_n     = '0;
                  tmo_n     = '0;
               end
            end else if (stare == S_INITIAL) begin
               nxt = smp_st;
            end else if (smp_st == stare) begin
               run_n = '0;
            end else begin
               // Debounce counts consecutive valid samples of one differing zone.
               pend_n = zone;
               if (run_inc == DEB_V) begin
                  nxt   = smp_st;
                  run_n = '0;
               end else begin
                  run_n = run_inc;
               end
            end
         end
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stare     <= S_IDLE;
         stare_chg <= 1'b0;
         up_cnt    <= '0;
         down_cnt  <= '0;
         timeout   <= 1'b0;
         run       <= '0;
         pend      <= Z_MIJLOC;
         tmo_cnt   <= '0;
      end else begin
         stare     <= nxt;
         stare_chg <= (nxt != stare);
         timeout   <= timeout_n;
         run       <= run_n;
         pend      <= pend_n;
         tmo_cnt   <= tmo_n;
         if (clr_cnt) begin
            up_cnt   <= '0;
            down_cnt <= '0;
         end else begin
            if (nxt == S_SINGLE_UP && stare != S_SINGLE_UP && up_cnt != CNT_MAX)
               up_cnt <= up_cnt + 1'b1;
            if (nxt == S_SINGLE_DOWN && stare != S_SINGLE_DOWN && down_cnt != CNT_MAX)
               down_cnt <= down_cnt + 1'b1;
         end
      end
   end

endmodule
